// File: rtl/param_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy, almost flags, flush and sticky misuse flags.
// Write-to-visible latency 1 cycle; writes are blocked by wr_full and reads by rd_empty, with misuse recorded in overflow/underflow.
module param_sync_fifo #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int AF = D - 1,
    parameter int AE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [W-1:0]           wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic                   wr_almost_full,
    output logic [W-1:0]           rd_data,
    input  logic                   rd_en,
    output logic                   rd_empty,
    output logic                   rd_almost_empty,
    output logic [$clog2(D):0]     count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int A = $clog2(D);
    localparam logic [A:0] PTR_ONE = {{A{1'b0}}, 1'b1};
    localparam logic [A:0] AF_V    = (A+1)'(AF);
    localparam logic [A:0] AE_V    = (A+1)'(AE);

    logic [W-1:0] mem_q [D];
    logic [W-1:0] mem_d [D];
    logic [A:0]   wr_ptr_q, wr_ptr_d;
    logic [A:0]   rd_ptr_q, rd_ptr_d;
    logic [A:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         afull_q, afull_d;
    logic         aempty_q, aempty_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         writing, reading;

    assign writing = wr_en & ~full_q;
    assign reading = rd_en & ~empty_q;

    always_comb begin
        mem_d = mem_q;
        // Data offered in a flush or reset cycle is dropped, so storage is left alone.
        if (writing && !flush && !reset) begin
            mem_d[wr_ptr_q[A-1:0]] = wr_data;
        end
    end

    // Flags derive from the next pointers so they line up with the pointer update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (reset || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (writing) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (reading) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[A] != rd_ptr_d[A]) && (wr_ptr_d[A-1:0] == rd_ptr_d[A-1:0]);
        afull_d  = (count_d >= AF_V);
        aempty_d = (count_d <= AE_V);
    end

    always_comb begin
        overflow_d  = overflow_q  | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
        if (reset) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= (AF == 0);
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_full         = full_q;
    assign wr_almost_full  = afull_q;
    assign rd_empty        = empty_q;
    assign rd_almost_empty = aempty_q;
    assign count           = count_q;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign rd_data         = mem_q[rd_ptr_q[A-1:0]];

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= (A+1)'(D)) else $error("count exceeds depth");
            assert (full_q == (count_q == (A+1)'(D))) else $error("full inconsistent with count");
            assert (empty_q == (count_q == '0)) else $error("empty inconsistent with count");
        end
    end
`endif
endmodule
